// File: rtl/epp_i2c_in_pio.sv
// Avalon-MM input port for the bit-banged I2C master: it synchronises and glitch-filters SCL/SDA,
// captures selected edges and raises a maskable level interrupt.
module epp_i2c_in_pio #(
    parameter int   WIDTH         = 2,
    parameter int   FILTER_CYCLES = 3,
    parameter int   EDGE_TYPE     = 2,
    parameter logic IDLE_LEVEL    = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [7:0] CNT_LAST = 8'(FILTER_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] filt_q, filt_d;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;

    // Only the low WIDTH bits of writedata carry register contents.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_en = chipselect && !write_n;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [7:0] cnt_q, cnt_d;
            logic       differs, upd;

            assign differs = (sync2_q[gi] != filt_q[gi]);
            // The filtered bit follows sync2 only after FILTER_CYCLES consecutive disagreeing samples.
            assign upd         = differs && (cnt_q == CNT_LAST);
            assign cnt_d       = (!differs || upd) ? 8'd0 : cnt_q + 8'd1;
            assign filt_d[gi]  = upd ? sync2_q[gi] : filt_q[gi];
            assign edge_set[gi] = upd && ((EDGE_TYPE == 2) ||
                                          (EDGE_TYPE == 0 &&  sync2_q[gi]) ||
                                          (EDGE_TYPE == 1 && !sync2_q[gi]));

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= 8'd0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    always_comb begin
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        if (wr_en && address == 2'd2) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd3) begin
            edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
        end
        // A newly captured edge takes priority over a simultaneous clear.
        edgecap_d = edgecap_d | edge_set;
    end

    always_comb begin
        readdata_d = 32'd0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = filt_q;
            2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
            2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
            default: readdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= {WIDTH{IDLE_LEVEL}};
            sync2_q    <= {WIDTH{IDLE_LEVEL}};
            filt_q     <= {WIDTH{IDLE_LEVEL}};
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= 32'd0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: doc/epp_i2c_in_pio.md
# epp_i2c_in_pio

Avalon-MM slave input port that samples the I2C bus lines (SCL, SDA) back into the Nios II for the bit-banged EPP I2C master. It is the read-side counterpart of the output-only SCL/SDA drive ports. It synchronises and glitch-filters each line, latches selected edges, and raises a maskable interrupt so firmware can detect clock stretching and arbitration loss without busy-polling.

## Interface
- WIDTH, 2, number of input lines (bit 0 = SCL, bit 1 = SDA); legal 1..32
- FILTER_CYCLES, 3, consecutive stable clocks required before a filtered bit changes; legal 1..255
- EDGE_TYPE, 2, edges captured: 0 rising, 1 falling, 2 any
- IDLE_LEVEL, 1, reset value of synchroniser and filtered bits (I2C idle high)

- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low; clock clk
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- in_port  in  WIDTH  raw asynchronous pad inputs
- irq  out  1  level interrupt, active-high

## Operation
- Register map (word addresses):
  - 0: data, read-only. Filtered bits, zero-extended. Writes are ignored.
  - 1: reserved. Reads 0; writes are ignored.
  - 2: irqmask, read/write, WIDTH bits.
  - 3: edgecapture, read; write-1-to-clear per bit.
- Write strobe: chipselect && !write_n. Only writedata[WIDTH-1:0] is used. Reads have no side effects.
- Synchroniser, per bit: two-flop chain sync1 then sync2.
- Glitch filter, per bit: 8-bit counter cnt and filtered register filt.
  - sync2 == filt: cnt <= 0.
  - sync2 != filt and cnt == FILTER_CYCLES-1: filt <= sync2 and cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Any return of sync2 to filt before the threshold restarts the count from 0.
- Edge capture, per bit: the edge is detected on the clock edge where filt updates.
  - Rising means filt goes 0 to 1.
  - The edgecapture bit is set if the edge matches EDGE_TYPE.
  - If a set and a write-1-clear hit the same bit in the same cycle, the set wins.
  - A write with a 0 in a bit leaves that bit unchanged.
- irq = |(edgecapture & irqmask). It is combinational from registers and has no extra delay.
- Reset values:
  - sync1, sync2, filt: all bits = IDLE_LEVEL.
  - cnt: 0.
  - irqmask, edgecapture: 0.
  - readdata: 0.
  - irq: 0.

## Timing
- readdata is updated on every clock edge from the current address, so read latency is 1 cycle.
- Pin-to-filt latency: the pin changes and is stable before edge E0.
  - sync1 captures at E0; sync2 at E1.
  - filt and edgecapture update at E(1+FILTER_CYCLES).
  - irq rises at that same edge.
  - data is visible on readdata one edge after the read address is presented, at the earliest E(2+FILTER_CYCLES).
- A pulse lasting fewer than FILTER_CYCLES consecutive sync2 cycles never reaches filt and never sets edgecapture.
- irqmask and edgecapture writes take effect at the write edge. irq responds in the same cycle as the register change.
- Reset assertion mid-filter clears cnt and forces filt to IDLE_LEVEL immediately, with no edge captured. After release, a pin held at the opposite level produces a normal edge after the full latency.

## Test plan
- Reset with in_port=2'b11 and no writes:
  - readdata is 0 at all addresses except address 0, which reads 0x3.
  - irq stays 0.
- FILTER_CYCLES=3, EDGE_TYPE=2, irqmask=0x1. SCL driven 1 to 0 and held, stable before E0:
  - filt[0]=0 and edgecapture=0x1 at E4.
  - irq=1 at E4.
  - A read at address 0 returns 0x2.
- SCL glitches low for 2 cycles, then high:
  - filt, edgecapture and irq remain unchanged.
  - A 3-cycle low pulse is captured.
- With edgecapture=0x3, write 0x1 to address 3:
  - edgecapture reads 0x2.
  - irq=0 if irqmask=0x1.
- In the same cycle, write 0x2 to address 3 while an SDA edge completes filtering:
  - edgecapture[1] stays 1.
- Assert reset_n while a transition is in progress (cnt=1):
  - all outputs are at reset values.
  - with the pin held 0 after release, edgecapture[0] sets at E(1+FILTER_CYCLES) after release.
